// File: rtl/i8080_cmd_ctrl.sv
// rtl/i8080_cmd_ctrl.sv - i8080 command decoder, window registers and framebuffer write sequencer
module i8080_cmd_ctrl #(
  parameter int H_RES  = 800,
  parameter int V_RES  = 480,
  parameter int ADDR_W = 19
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              BUS_WR,
  input  logic              BUS_DC,
  input  logic [15:0]       BUS_DATA,
  input  logic              FB_READY,
  output logic              FB_WE,
  output logic [ADDR_W-1:0] FB_ADDR,
  output logic [15:0]       FB_DATA,
  output logic              BUSY,
  output logic              DISP_ON,
  output logic              FRAME_DONE,
  output logic              OVERRUN
);

  typedef enum logic [2:0] {S_IDLE, S_CASET, S_PASET, S_CALC, S_PIXEL} state_t;

  localparam logic [15:0]       H_MAX   = 16'(H_RES - 1);
  localparam logic [15:0]       V_MAX   = 16'(V_RES - 1);
  localparam logic [ADDR_W-1:0] H_RES_A = ADDR_W'(H_RES);

  state_t            state;
  logic [1:0]        idx;
  logic              calc_phase;
  logic              ready_q;
  logic [15:0]       sc, ec, sp, ep, col, row;
  logic              col_ok, row_ok;
  logic [7:0]        sh_start_hi, sh_start_lo, sh_end_hi;
  logic [ADDR_W-1:0] row_base, row_base_top, prod;

  logic              drop, accept, soft_rst;
  logic [15:0]       lim, p_start, p_end, c_start, c_end;

  // A write is dropped only when the port was already stalled last cycle, so a
  // write landing in the cycle FB_READY falls still completes.
  assign BUSY     = (state == S_CALC) | ~FB_READY;
  assign drop     = (state == S_CALC) | (~FB_READY & ~ready_q);
  assign accept   = BUS_WR & ~drop;
  assign soft_rst = accept & ~BUS_DC & (BUS_DATA[7:0] == 8'h01);

  assign lim     = (state == S_CASET) ? H_MAX : V_MAX;
  assign p_start = {sh_start_hi, sh_start_lo};
  assign p_end   = {sh_end_hi, BUS_DATA[7:0]};
  assign c_start = (p_start > lim) ? lim : p_start;
  assign c_end   = (p_end > lim) ? lim : p_end;

  always_ff @(posedge CLK) begin
    ready_q <= FB_READY;
    if (RST || soft_rst) begin
      state        <= S_IDLE;
      idx          <= 2'd0;
      calc_phase   <= 1'b0;
      sc           <= 16'd0;
      ec           <= H_MAX;
      sp           <= 16'd0;
      ep           <= V_MAX;
      col_ok       <= 1'b1;
      row_ok       <= 1'b1;
      col          <= 16'd0;
      row          <= 16'd0;
      row_base     <= '0;
      row_base_top <= '0;
      prod         <= '0;
      sh_start_hi  <= 8'd0;
      sh_start_lo  <= 8'd0;
      sh_end_hi    <= 8'd0;
      FB_WE        <= 1'b0;
      FB_ADDR      <= '0;
      FB_DATA      <= 16'd0;
      DISP_ON      <= 1'b0;
      FRAME_DONE   <= 1'b0;
      OVERRUN      <= 1'b0;
    end else begin
      FB_WE      <= 1'b0;
      FRAME_DONE <= 1'b0;
      if (BUS_WR && drop)
        OVERRUN <= 1'b1;

      if (state == S_CALC) begin
        if (!calc_phase) begin
          prod       <= ADDR_W'(sp) * H_RES_A;
          calc_phase <= 1'b1;
        end else begin
          row_base     <= prod;
          row_base_top <= prod;
          calc_phase   <= 1'b0;
          state        <= S_PIXEL;
        end
      end else if (accept && !BUS_DC) begin
        idx <= 2'd0;
        case (BUS_DATA[7:0])
          8'h2A: state <= S_CASET;
          8'h2B: state <= S_PASET;
          8'h2C: begin
            col        <= sc;
            row        <= sp;
            calc_phase <= 1'b0;
            state      <= S_CALC;
          end
          8'h3C: state <= S_PIXEL;
          8'h29: begin DISP_ON <= 1'b1; state <= S_IDLE; end
          8'h28: begin DISP_ON <= 1'b0; state <= S_IDLE; end
          default: state <= S_IDLE;
        endcase
      end else if (accept) begin
        case (state)
          S_CASET, S_PASET: begin
            idx <= idx + 2'd1;
            case (idx)
              2'd0: sh_start_hi <= BUS_DATA[7:0];
              2'd1: sh_start_lo <= BUS_DATA[7:0];
              2'd2: sh_end_hi   <= BUS_DATA[7:0];
              default: begin
                if (state == S_CASET) begin
                  sc     <= c_start;
                  ec     <= c_end;
                  col_ok <= (c_start <= c_end);
                end else begin
                  sp     <= c_start;
                  ep     <= c_end;
                  row_ok <= (c_start <= c_end);
                end
                state <= S_IDLE;
              end
            endcase
          end
          S_PIXEL: begin
            if (col_ok && row_ok) begin
              FB_WE   <= 1'b1;
              FB_DATA <= BUS_DATA;
              FB_ADDR <= row_base + ADDR_W'(col);
              if (col < ec) begin
                col <= col + 16'd1;
              end else begin
                col <= sc;
                if (row < ep) begin
                  row      <= row + 16'd1;
                  row_base <= row_base + H_RES_A;
                end else begin
                  // Wrap to the window top from the copy taken at the last CALC
                  row        <= sp;
                  row_base   <= row_base_top;
                  FRAME_DONE <= 1'b1;
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i8080_cmd_ctrl.sv
// tb/tb_i8080_cmd_ctrl.sv - directed and randomized bench for i8080_cmd_ctrl
module tb_i8080_cmd_ctrl;

  localparam int H  = 800;
  localparam int V  = 480;
  localparam int AW = 19;

  logic          CLK = 1'b0;
  logic          RST, BUS_WR, BUS_DC, FB_READY;
  logic [15:0]   BUS_DATA;
  logic          FB_WE, BUSY, DISP_ON, FRAME_DONE, OVERRUN;
  logic [AW-1:0] FB_ADDR;
  logic [15:0]   FB_DATA;

  i8080_cmd_ctrl #(.H_RES(H), .V_RES(V), .ADDR_W(AW)) dut (
    .CLK(CLK), .RST(RST), .BUS_WR(BUS_WR), .BUS_DC(BUS_DC), .BUS_DATA(BUS_DATA),
    .FB_READY(FB_READY), .FB_WE(FB_WE), .FB_ADDR(FB_ADDR), .FB_DATA(FB_DATA),
    .BUSY(BUSY), .DISP_ON(DISP_ON), .FRAME_DONE(FRAME_DONE), .OVERRUN(OVERRUN)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [15:0]   data;
    logic          fd;
  } exp_t;
  exp_t q[$];

  // Reference model: window as plain integers, addresses as row*H+col
  int m_sc, m_ec, m_sp, m_ep, m_col, m_row, m_mode, m_idx;
  int m_p[4];
  bit m_cok, m_rok, m_disp, m_ovr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mdl_reset();
    m_sc = 0; m_ec = H - 1; m_sp = 0; m_ep = V - 1;
    m_cok = 1; m_rok = 1; m_col = 0; m_row = 0;
    m_mode = 0; m_idx = 0; m_disp = 0; m_ovr = 0;
  endtask

  task automatic mdl_cmd(input int c);
    case (c)
      'h2A: begin m_mode = 1; m_idx = 0; end
      'h2B: begin m_mode = 2; m_idx = 0; end
      'h2C: begin m_col = m_sc; m_row = m_sp; m_mode = 3; end
      'h3C: m_mode = 3;
      'h29: begin m_disp = 1; m_mode = 0; end
      'h28: begin m_disp = 0; m_mode = 0; end
      'h01: mdl_reset();
      default: m_mode = 0;
    endcase
  endtask

  task automatic mdl_dat(input int d);
    exp_t e;
    int s, en, lim;
    if (m_mode == 1 || m_mode == 2) begin
      m_p[m_idx] = d & 255;
      m_idx++;
      if (m_idx == 4) begin
        s   = m_p[0] * 256 + m_p[1];
        en  = m_p[2] * 256 + m_p[3];
        lim = ((m_mode == 1) ? H : V) - 1;
        if (s > lim) s = lim;
        if (en > lim) en = lim;
        if (m_mode == 1) begin m_sc = s; m_ec = en; m_cok = (s <= en); end
        else             begin m_sp = s; m_ep = en; m_rok = (s <= en); end
        m_mode = 0;
      end
    end else if (m_mode == 3 && m_cok && m_rok) begin
      e.addr = AW'(m_row * H + m_col);
      e.data = 16'(d);
      e.fd   = (m_col == m_ec && m_row == m_ep);
      q.push_back(e);
      if (m_col < m_ec) m_col++;
      else begin
        m_col = m_sc;
        if (m_row < m_ep) m_row++;
        else m_row = m_sp;
      end
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (BUSY !== 1'b0 && n < 40) begin
      @(posedge CLK); #1;
      n++;
    end
    if (n == 40) chk("busy_timeout", {31'b0, BUSY}, 32'd0);
  endtask

  task automatic bus_wr(input bit dc, input int d);
    wait_ready();
    BUS_WR = 1'b1; BUS_DC = dc; BUS_DATA = 16'(d);
    @(posedge CLK); #1;
    BUS_WR = 1'b0;
    if (dc) mdl_dat(d); else mdl_cmd(d);
  endtask

  task automatic cmd(input int c); bus_wr(1'b0, c); endtask
  task automatic dat(input int d); bus_wr(1'b1, d); endtask

  task automatic params(input int c, input int s, input int e);
    cmd(c);
    dat(s >> 8); dat(s & 255); dat(e >> 8); dat(e & 255);
  endtask

  // Output monitor, sampled on the falling edge
  always @(negedge CLK) begin
    if (RST === 1'b0) begin
      if (FB_WE === 1'b1) begin
        if (q.size() == 0) chk("fb_we_unexpected", {31'b0, FB_WE}, 32'd0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("fb_addr", 32'(FB_ADDR), 32'(e.addr));
          chk("fb_data", 32'(FB_DATA), 32'(e.data));
          chk("frame_done", {31'b0, FRAME_DONE}, {31'b0, e.fd});
        end
      end else if (FRAME_DONE !== 1'b0) begin
        chk("frame_done_alone", {31'b0, FRAME_DONE}, 32'd0);
      end
      chk("disp_on", {31'b0, DISP_ON}, {31'b0, m_disp});
      chk("overrun", {31'b0, OVERRUN}, {31'b0, m_ovr});
    end
  end

  initial begin
    int sc, w, sp, h, n;
    RST = 1'b1; BUS_WR = 1'b0; BUS_DC = 1'b0; BUS_DATA = 16'd0; FB_READY = 1'b1;
    mdl_reset();
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_fb_we", {31'b0, FB_WE}, 32'd0);
    chk("rst_fb_addr", 32'(FB_ADDR), 32'd0);
    chk("rst_fb_data", 32'(FB_DATA), 32'd0);
    chk("rst_disp_on", {31'b0, DISP_ON}, 32'd0);
    chk("rst_frame_done", {31'b0, FRAME_DONE}, 32'd0);
    chk("rst_overrun", {31'b0, OVERRUN}, 32'd0);
    RST = 1'b0;
    @(posedge CLK); #1;
    chk("idle_busy", {31'b0, BUSY}, 32'd0);

    // 0x2C: two CALC cycles of BUSY, then three pixels at 0,1,2
    cmd('h2C);
    chk("calc_busy_1", {31'b0, BUSY}, 32'd1);
    @(posedge CLK); #1;
    chk("calc_busy_2", {31'b0, BUSY}, 32'd1);
    @(posedge CLK); #1;
    chk("calc_busy_end", {31'b0, BUSY}, 32'd0);
    dat('hF800); dat('h07E0); dat('h001F);

    // 3x2 window at (10,5): 4010..4812, wrap on 7th pixel
    params('h2A, 10, 12);
    params('h2B, 5, 6);
    cmd('h2C);
    for (int i = 0; i < 7; i++) dat($urandom_range(0, 65535));

    // Clipping of out-of-range columns
    cmd('h01);
    params('h2A, 'h0320, 'h03FF);
    cmd('h2C);
    dat('h1234);

    // Invalid window then recovery
    cmd('h01);
    params('h2A, 20, 10);
    cmd('h2C);
    for (int i = 0; i < 5; i++) dat($urandom_range(0, 65535));
    params('h2A, 0, 1);
    cmd('h2C);
    dat('hAAAA); dat('h5555);

    // Stall with overrun, then soft reset
    cmd('h3C);
    FB_READY = 1'b0;
    @(posedge CLK); #1;
    repeat (2) begin
      BUS_WR = 1'b1; BUS_DC = 1'b1; BUS_DATA = 16'($urandom_range(0, 65535));
      @(posedge CLK); #1;
      BUS_WR = 1'b0;
      m_ovr = 1;
      chk("stall_busy", {31'b0, BUSY}, 32'd1);
      @(posedge CLK); #1;
    end
    FB_READY = 1'b1;
    cmd('h01);
    chk("softrst_overrun", {31'b0, OVERRUN}, 32'd0);
    cmd('h2C);
    dat('h0101); dat('h0202); dat('h0303);

    // Display enable and 0x3C continuation
    cmd('h01);
    cmd('h29);
    cmd('h2C);
    dat('h1111); dat('h2222);
    cmd('h3C);
    dat('h3333);
    cmd('h28);

    // FB_READY falling in the same cycle as an accepted pixel
    cmd('h3C);
    BUS_WR = 1'b1; BUS_DC = 1'b1; BUS_DATA = 16'hABCD; FB_READY = 1'b0;
    @(posedge CLK); #1;
    BUS_WR = 1'b0;
    mdl_dat('hABCD);
    chk("ready_fall_busy", {31'b0, BUSY}, 32'd1);
    @(posedge CLK); #1;
    FB_READY = 1'b1;

    // Randomized windows, occasionally with an aborted parameter sequence
    for (int it = 0; it < 8; it++) begin
      sc = $urandom_range(0, 40); w = $urandom_range(1, 5);
      sp = $urandom_range(0, 30); h = $urandom_range(1, 4);
      params('h2A, sc, sc + w - 1);
      params('h2B, sp, sp + h - 1);
      if (it % 3 == 2) begin cmd('h2A); dat(0); dat(7); end
      cmd('h2C);
      n = $urandom_range(1, 2 * w * h + 1);
      for (int i = 0; i < n; i++) dat($urandom_range(0, 65535));
      if (it % 2 == 1) cmd('h00);
    end

    repeat (4) @(posedge CLK);
    #1;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
